// File: rtl/conta_sched_pkg.sv
// rtl/conta_sched_pkg.sv - shared types, default widths and round-robin pick for conta_sched
package conta_sched_pkg;

    localparam int LARGO_DEF = 6;
    localparam int N_REQ_DEF = 4;
    localparam int N_MAX     = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // First set request at or after ptr, wrapping within the n live requesters.
    function automatic logic [N_MAX-1:0] rr_pick(input logic [N_MAX-1:0] req,
                                                 input logic [2:0]       ptr,
                                                 input int unsigned      n);
        logic [N_MAX-1:0] onehot;
        logic [2:0]       pos;
        onehot = '0;
        for (int unsigned k = 0; k < N_MAX; k++) begin
            pos = 3'((32'(ptr) + k) % n);
            if (k < n && onehot == '0 && req[pos]) onehot[pos] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/conta_unit.sv
// rtl/conta_unit.sv - LARGO-bit interval counter, clear has priority over enable
module conta_unit #(
    parameter int LARGO = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             ena_i,
    output logic [LARGO-1:0] cuenta_o
);

    logic [LARGO-1:0] cuenta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cuenta_q <= '0;
        end else if (clr_i) begin
            cuenta_q <= '0;
        end else if (ena_i) begin
            cuenta_q <= cuenta_q + LARGO'(1);
        end
    end

    assign cuenta_o = cuenta_q;

endmodule

// File: rtl/conta_sched.sv
// rtl/conta_sched.sv - round-robin scheduler sharing one interval counter; SCHED_ABORT_EN enables abort on req drop
module conta_sched
    import conta_sched_pkg::*;
#(
    parameter int LARGO = LARGO_DEF,
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*LARGO-1:0] dur_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       ack_o,
    output logic                   busy_o,
    output logic [LARGO-1:0]       cuenta_o
);

    localparam int PW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d;
    logic [PW-1:0]    pick_idx, ptr_nxt;
    logic [LARGO-1:0] dur_q, dur_d, pick_dur;
    logic [N_MAX-1:0] pick;
    logic             clr, ena, last, abort;

    assign pick = rr_pick(N_MAX'(req_i), 3'(ptr_q), N_REQ);

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_MAX; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        pick_dur = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == PW'(i)) pick_dur = dur_i[i*LARGO +: LARGO];
        end
    end

    assign ptr_nxt = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
    assign last    = (cuenta_o == dur_q - LARGO'(1));

`ifdef SCHED_ABORT_EN
    assign abort = ~req_i[win_q];
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        dur_d   = dur_q;
        clr     = 1'b0;
        ena     = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (|req_i) begin
                    state_d = RUN;
                    win_d   = pick_idx;
                    // A zero-length request still occupies the counter for one cycle.
                    dur_d   = (pick_dur == '0) ? LARGO'(1) : pick_dur;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                    ptr_d   = ptr_nxt;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    ena = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                clr     = 1'b1;
                ptr_d   = ptr_nxt;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            dur_q   <= LARGO'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            dur_q   <= dur_d;
        end
    end

    conta_unit #(.LARGO(LARGO)) u_conta (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr),
        .ena_i    (ena),
        .cuenta_o (cuenta_o)
    );

    assign busy_o = (state_q != IDLE);
    assign gnt_o  = busy_o ? (N_REQ'(1) << win_q) : '0;
    assign ack_o  = (state_q == DONE) ? (N_REQ'(1) << win_q) : '0;

endmodule

// File: tb/tb_conta_sched.sv
// tb/tb_conta_sched.sv - directed and randomized checks of conta_sched against an interval-level model
module tb_conta_sched;

    localparam int L = 6;
    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*L-1:0] dur;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic           busy;
    logic [L-1:0]   cuenta;

    int n_chk  = 0;
    int n_fail = 0;
    int m_ptr  = 0;
    int dur_a [N];

    conta_sched #(.LARGO(L), .N_REQ(N)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .dur_i    (dur),
        .gnt_o    (gnt),
        .ack_o    (ack),
        .busy_o   (busy),
        .cuenta_o (cuenta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_dur();
        for (int i = 0; i < N; i++) dur[i*L +: L] = L'(dur_a[i]);
    endtask

    function automatic int model_pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cnt"}, cuenta, 0);
    endtask

    // Caller is in an IDLE cycle with req set; checks a full interval for winner w.
    task automatic grant_cycle(input int w, input int d, input bit rnd);
        int eff;
        eff = (d == 0) ? 1 : d;
        for (int c = 0; c < eff; c++) begin
            step();
            chk("run_gnt", gnt, 32'(1 << w));
            chk("run_cnt", cuenta, c);
            chk("run_ack", ack, 0);
            chk("run_busy", busy, 1);
            if (rnd) begin
                for (int i = 0; i < N; i++) begin
                    if (i != w) req[i] = 1'($urandom_range(0, 1));
                    dur_a[i] = $urandom_range(0, 15);
                end
                pack_dur();
            end
        end
        step();
        chk("done_gnt", gnt, 32'(1 << w));
        chk("done_ack", ack, 32'(1 << w));
        chk("done_cnt", cuenta, eff - 1);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) dur_a[i] = 0;
        pack_dur();
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // single requester, dur=5
        req = 4'b0010; dur_a[1] = 5; pack_dur();
        w = model_pick(req);
        grant_cycle(w, 5, 0);
        req = '0;
        step();
        chk_idle("t2_idle");

        // asynchronous reset in the middle of a run
        req = 4'b0001; dur_a[0] = 8; pack_dur();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_cnt", cuenta, c);
        end
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        req = '0;
        step();
        rst_n = 1'b1;
        m_ptr = 0;

        // all requesting, equal durations: strict rotation
        req = 4'b1111;
        for (int i = 0; i < N; i++) dur_a[i] = 2;
        pack_dur();
        for (int g = 0; g < 5; g++) begin
            w = model_pick(req);
            chk("rr_order", w, g % N);
            grant_cycle(w, 2, 0);
            step();
            chk_idle("rr_gap");
        end
        req = '0;
        step();

        // zero duration behaves as one
        req = 4'b0100; dur_a[2] = 0; pack_dur();
        w = model_pick(req);
        grant_cycle(w, 0, 0);
        req = '0;
        step();
        chk_idle("dur0_idle");

        // maximum duration
        req = 4'b0001; dur_a[0] = 63; pack_dur();
        w = model_pick(req);
        grant_cycle(w, 63, 0);
        req = '0;
        step();
        chk_idle("dmax_idle");

        // requester drops mid-run
        req = 4'b0010; dur_a[1] = 10; pack_dur();
        w = model_pick(req);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("ab_cnt", cuenta, c);
            chk("ab_gnt", gnt, 32'(1 << w));
        end
        req[1] = 1'b0;
`ifdef SCHED_ABORT_EN
        step();
        chk_idle("abort");
        m_ptr = (w + 1) % N;
`else
        for (int c = 3; c < 10; c++) begin
            step();
            chk("noab_cnt", cuenta, c);
            chk("noab_ack", ack, 0);
        end
        step();
        chk("noab_done_ack", ack, 32'(1 << w));
        chk("noab_done_cnt", cuenta, 9);
        m_ptr = (w + 1) % N;
        step();
        chk_idle("noab_idle");
`endif

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            req = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) dur_a[i] = $urandom_range(0, 7);
            pack_dur();
            if (req == '0) begin
                step();
                chk_idle("rnd_none");
            end else begin
                w = model_pick(req);
                grant_cycle(w, dur_a[w], 1);
                step();
                chk_idle("rnd_idle");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
